// File: rtl/om_est_pkg.sv
// Shared types and defaults for the omega-estimation sample path.
package om_est_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 12;
    // Pair count needs one extra bit so that lag=0 (P = N) is representable.
    localparam int PCNT_WIDTH_DEF = ADDR_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READ    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    function automatic int pcnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/rd_pair_stage.sv
// Two-stage read pipeline: p1 (RAM address registered, data on ram_dout_*)
// followed by the m_* output registers.
//
// Handshake: a pair transfers on a cycle where m_valid && m_ready. m_valid,
// once high, stays high and m_data_*/m_last stay stable until that transfer.
// adv = !m_valid || m_ready: the whole pipe moves only when the output
// register is empty or being emptied this cycle.
module rd_pair_stage
    import om_est_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic                  issue_last,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_b,
    input  logic                  m_ready,
    output logic                  adv,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data_a,
    output logic [DATA_WIDTH-1:0] m_data_b,
    output logic                  m_last
);

    logic                  p1_valid_q, p1_valid_d;
    logic                  p1_last_q,  p1_last_d;
    logic                  m_valid_q,  m_valid_d;
    logic                  m_last_q,   m_last_d;
    logic [DATA_WIDTH-1:0] m_data_a_q, m_data_a_d;
    logic [DATA_WIDTH-1:0] m_data_b_q, m_data_b_d;

    assign adv = !m_valid_q || m_ready;

    // Advance p1 -> out and accept a new issue into p1, or hold everything.
    always_comb begin
        p1_valid_d = p1_valid_q;
        p1_last_d  = p1_last_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_a_d = m_data_a_q;
        m_data_b_d = m_data_b_q;
        if (adv) begin
            m_valid_d = p1_valid_q;
            m_last_d  = p1_last_q;
            // Data only moves with a real beat, so idle outputs stay quiet.
            if (p1_valid_q) begin
                m_data_a_d = ram_dout_a;
                m_data_b_d = ram_dout_b;
            end
            p1_valid_d = issue;
            p1_last_d  = issue && issue_last;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_a_q <= '0;
            m_data_b_q <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_last_q  <= p1_last_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_a_q <= m_data_a_d;
            m_data_b_q <= m_data_b_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data_a = m_data_a_q;
    assign m_data_b = m_data_b_q;
    assign m_last   = m_last_q;

endmodule

// File: rtl/input_ram_ctrl.sv
// Sample RAM sequencer: captures one frame of N = 2**ADDR_WIDTH samples, then
// replays it as (x[k], x[k+lag]) pairs for the lag correlator.
//
// Handshakes: input samples transfer on s_valid && s_ready; output pairs
// transfer on m_valid && m_ready, with m_valid/m_data_*/m_last held stable
// until accepted.
module input_ram_ctrl
    import om_est_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] lag,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_b,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data_a,
    output logic [DATA_WIDTH-1:0] m_data_b,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state
);

    localparam int PW = pcnt_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0] p1_idx_q, p1_idx_d;
    logic [ADDR_WIDTH-1:0] lag_q,    lag_d;
    logic                  done_q,   done_d;

    logic [PW-1:0]         pair_cnt;
    logic [PW-1:0]         last_idx;
    logic                  issue;
    logic                  issue_last;
    logic                  adv;
    logic [ADDR_WIDTH-1:0] rd_sel;

    // P = N - lag; lag=0 gives the full frame (power mode).
    assign pair_cnt   = (PW'(1) << ADDR_WIDTH) - PW'(lag_q);
    assign last_idx   = pair_cnt - PW'(1);
    assign issue      = (state_q == ST_READ);
    assign issue_last = (PW'(rd_idx_q) == last_idx);

    // Next-state, counters and lag latch.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        p1_idx_d = p1_idx_q;
        lag_d    = lag_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lag_d    = lag;
                    wr_idx_d = '0;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (s_valid) begin
                    wr_idx_d = wr_idx_q + ADDR_WIDTH'(1);
                    if (wr_idx_q == IDX_LAST) begin
                        rd_idx_d = '0;
                        state_d  = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (adv) begin
                    p1_idx_d = rd_idx_q;
                    rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_valid && m_last && m_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; RAM contents are not affected by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            p1_idx_q <= '0;
            lag_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            p1_idx_q <= p1_idx_d;
            lag_q    <= lag_d;
            done_q   <= done_d;
        end
    end

    // While the pipe is stalled the RAM is re-pointed at the index already
    // sitting in p1, so the re-registered read returns the same data rather
    // than the next (not yet issued) sample.
    assign rd_sel     = adv ? rd_idx_q : p1_idx_q;
    assign ram_addr_a = (state_q == ST_CAPTURE) ? wr_idx_q : rd_sel;
    assign ram_addr_b = rd_sel + lag_q;

    assign s_ready   = (state_q == ST_CAPTURE);
    assign ram_we    = s_ready && s_valid;
    assign ram_din_a = s_ready ? s_data : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

    rd_pair_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pair_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_last (issue_last),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b),
        .m_ready    (m_ready),
        .adv        (adv),
        .m_valid    (m_valid),
        .m_data_a   (m_data_a),
        .m_data_b   (m_data_b),
        .m_last     (m_last)
    );

endmodule

// File: tb/tb_input_ram_ctrl.sv
// Bench for input_ram_ctrl with a small dual-port sample RAM model.
module tb_input_ram_ctrl;
  import om_est_pkg::*;

  localparam int AW = 4;
  localparam int DW = 12;
  localparam int N  = 1 << AW;
  localparam int PKT_W = 2 * DW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] lag;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_din_a;
  logic [DW-1:0] ram_dout_a;
  logic [DW-1:0] ram_dout_b;
  logic          m_valid;
  logic [DW-1:0] m_data_a;
  logic [DW-1:0] m_data_b;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  state_e        dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  input_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lag        (lag),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ram_we     (ram_we),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_a  (ram_din_a),
    .ram_dout_a (ram_dout_a),
    .ram_dout_b (ram_dout_b),
    .m_valid    (m_valid),
    .m_data_a   (m_data_a),
    .m_data_b   (m_data_b),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Dual-port RAM: registered address, one-cycle read latency on both ports.
  logic [DW-1:0] mem [0:N-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_din_a;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  // ---------------- scoreboard state ----------------
  int                 checks = 0;
  int                 errors = 0;
  logic [PKT_W-1:0]   exp_q[$];
  logic [DW-1:0]      x [0:N-1];
  bit                 mon_en = 0;
  bit                 stall_en = 0;
  bit                 cap_active = 0;
  int                 wr_exp = 0;
  int                 done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream backpressure driver.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: write-side checks, pair scoreboard, stall stability, done count.
  initial begin
    bit               hold;
    logic [PKT_W-1:0] held;
    logic [PKT_W-1:0] e;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'({m_data_a, m_data_b, m_last}), 32'(held));
        end
        check("ram_we", 32'(ram_we), 32'(cap_active && s_valid));
        if (ram_we && wr_exp < N) begin
          check("wr_addr", 32'(ram_addr_a), 32'(wr_exp));
          check("wr_data", 32'(ram_din_a), 32'(x[wr_exp]));
          wr_exp++;
        end
        if (done) done_cnt++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pair: got a=0x%0h b=0x%0h last=%0d expected none at %0t",
                     m_data_a, m_data_b, m_last, $time);
          end else begin
            e = exp_q.pop_front();
            check("pair", 32'({m_data_a, m_data_b, m_last}), 32'(e));
          end
        end
        hold = m_valid && !m_ready;
        held = {m_data_a, m_data_b, m_last};
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_frame(input int lag_v, input bit inc_data, input bit gaps,
                           input bit stalls, input bit poke, input bit chk_lat,
                           input int abort_at);
    int idx;
    int cyc;
    int d0;
    int p;
    bit acc;
    for (int k = 0; k < N; k++)
      x[k] = inc_data ? DW'(k + 1) : DW'($urandom_range(0, (1 << DW) - 1));
    // Reference: P = N - lag pairs (x[k], x[k+lag]), last flag on k = P-1.
    p = N - lag_v;
    for (int k = 0; k < p; k++)
      exp_q.push_back({x[k], x[k + lag_v], (k == p - 1)});
    stall_en = stalls;
    d0 = done_cnt;

    start = 1'b1;
    lag = lag_v[AW-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("state_capture", 32'(dbg_state), 32'(ST_CAPTURE));

    wr_exp = 0;
    cap_active = 1;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 500) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = x[idx];
      if (poke && idx == 5) begin
        start = 1'b1;
        lag = AW'($urandom_range(0, N - 1));
      end else begin
        start = 1'b0;
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    s_data = '0;
    start = 1'b0;
    cap_active = 0;
    check("capture_complete", 32'(idx), N);
    check("state_read", 32'(dbg_state), 32'(ST_READ));

    if (chk_lat) begin
      check("lat_t0", 32'(m_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_t1", 32'(m_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_t2", 32'(m_valid), 32'd1);
    end

    if (abort_at > 0) begin
      repeat (abort_at) begin
        @(posedge clk);
        #1;
      end
      mon_en = 0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      check("abort_m_valid", 32'(m_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_s_ready", 32'(s_ready), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_m_data", 32'({m_data_a, m_data_b, m_last}), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      stall_en = 0;
      mon_en = 1;
      @(posedge clk);
      #1;
      return;
    end

    cyc = 0;
    while (done_cnt == d0 && cyc < 500) begin
      start = (poke && dbg_state != ST_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
      lag = AW'($urandom_range(0, N - 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("frame_finished", 32'(done_cnt != d0), 32'd1);
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_after_done", 32'(dbg_state), 32'(ST_IDLE));
    check("busy_after_done", 32'(busy), 32'd0);
    check("pairs_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stall_en = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("still_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    lag = '0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_a", 32'(ram_addr_a), 32'd0);
    check("rst_addr_b", 32'(ram_addr_b), 32'd0);
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;

    // lag, inc_data, gaps, stalls, poke, chk_lat, abort_at
    run_frame(3,  1, 0, 0, 0, 1, 0);
    run_frame(0,  1, 0, 0, 0, 1, 0);
    run_frame(15, 1, 0, 0, 0, 1, 0);
    run_frame(3,  1, 0, 1, 1, 0, 0);
    run_frame(3,  1, 1, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      run_frame($urandom_range(0, N - 1), 0, 1, 1, 1, 0, 0);
    run_frame(5,  0, 1, 1, 0, 0, 4);
    run_frame(7,  0, 0, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
